// File: rtl/vespa_int_pkg.sv
// Shared constants and FSM encoding for the VeSPA interrupt controller.
package vespa_int_pkg;

    localparam int VESPA_INT_NUM_SRC = 4;
    localparam int VESPA_INT_ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_e;

endpackage

// File: rtl/vespa_int_prio_enc.sv
// Combinational rotating priority encoder: first set bit of elig searching base, base+1, ... (mod 4).
module vespa_int_prio_enc
    import vespa_int_pkg::*;
(
    input  logic [VESPA_INT_NUM_SRC-1:0] elig,
    input  logic [VESPA_INT_ID_W-1:0]    base,
    output logic                         valid,
    output logic [VESPA_INT_ID_W-1:0]    id
);

    // Walk from the farthest offset to the nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        id    = base;
        for (int k = VESPA_INT_NUM_SRC - 1; k >= 0; k--) begin
            if (elig[base + 2'(k)]) begin
                valid = 1'b1;
                id    = base + 2'(k);
            end
        end
    end

endmodule

// File: rtl/vespa_int_controller.sv
// Four-source interrupt scheduler driving the VeSPA request/attended/complete handshake.
// Fixed priority (source 0 highest) by default; VESPA_INT_ROTATE_PRIO_EN selects round-robin.
module vespa_int_controller
    import vespa_int_pkg::*;
#(
    parameter int NUM_SRC   = VESPA_INT_NUM_SRC,
    parameter bit EDGE_TRIG = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_src,
    input  logic                      mask_wr,
    input  logic [NUM_SRC-1:0]        mask_din,
    output logic [NUM_SRC-1:0]        mask_q,
    output logic [NUM_SRC-1:0]        pending_q,
    output logic                      int_req,
    output logic [VESPA_INT_ID_W-1:0] int_number,
    input  logic                      int_ack_attended,
    input  logic                      int_ack_complete,
    output logic                      in_service
);

    int_state_e                state_q, state_d;
    logic [NUM_SRC-1:0]        src_d_q;
    logic [NUM_SRC-1:0]        src_evt;
    logic [NUM_SRC-1:0]        mask_d, pending_d, pend_clr;
    logic [VESPA_INT_ID_W-1:0] int_number_q, int_number_d;
    logic [VESPA_INT_ID_W-1:0] prio_base;
    logic                      win_vld;
    logic [VESPA_INT_ID_W-1:0] win_id;

    generate
        if (EDGE_TRIG) begin : g_edge
            assign src_evt = irq_src & ~src_d_q;
        end else begin : g_level
            assign src_evt = irq_src;
        end
    endgenerate

`ifdef VESPA_INT_ROTATE_PRIO_EN
    logic [VESPA_INT_ID_W-1:0] ptr_q, ptr_d;
    assign prio_base = ptr_q;
`else
    assign prio_base = '0;
`endif

    vespa_int_prio_enc u_prio_enc (
        .elig  (pending_q & ~mask_q),
        .base  (prio_base),
        .valid (win_vld),
        .id    (win_id)
    );

    always_comb begin
        state_d      = state_q;
        int_number_d = int_number_q;
        pend_clr     = '0;
`ifdef VESPA_INT_ROTATE_PRIO_EN
        ptr_d        = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d      = ST_REQ;
                    int_number_d = win_id;
                end
            end
            ST_REQ: begin
                if (int_ack_attended) begin
                    state_d                = ST_SERVICE;
                    pend_clr[int_number_q] = 1'b1;
`ifdef VESPA_INT_ROTATE_PRIO_EN
                    ptr_d                  = int_number_q + 2'd1;
`endif
                end
            end
            ST_SERVICE: begin
                if (int_ack_complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh event on the source being cleared survives the clear.
        pending_d = (pending_q & ~pend_clr) | src_evt;
        mask_d    = mask_wr ? mask_din : mask_q;
    end

    always_ff @(posedge clk) begin
        src_d_q <= irq_src;
        if (rst) begin
            state_q      <= ST_IDLE;
            int_number_q <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
`ifdef VESPA_INT_ROTATE_PRIO_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            int_number_q <= int_number_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
`ifdef VESPA_INT_ROTATE_PRIO_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign int_req    = (state_q == ST_REQ);
    assign in_service = (state_q == ST_SERVICE);
    assign int_number = int_number_q;

endmodule
